// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter with first-word-fall-through head
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic [AW:0]   thr,
    output logic [7:0]    tx_data,
    output logic          req,
    input  logic          next_tx,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          irq_low
);

    localparam logic [AW:0]   CNT_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;

    assign w_full    = (r_count == CNT_DEPTH);
    assign w_empty   = (r_count == '0);
    // Flush wins over both sides of the FIFO in the same cycle.
    assign w_push    = wr_en && !w_full && !flush;
    assign w_pop     = next_tx && !w_empty && !flush;
    assign w_ovf_set = wr_en && w_full && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Sticky flag: a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx_data  = w_empty ? 8'hFF : r_mem[r_rd_ptr];
    assign req      = !w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign irq_low  = (r_count <= thr);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed vector bench for uart_tx_fifo at DEPTH=4
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_ovf;
    logic [2:0] thr;
    logic [7:0] tx_data;
    logic       req;
    logic       next_tx;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       irq_low;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .clr_ovf(clr_ovf), .thr(thr), .tx_data(tx_data),
        .req(req), .next_tx(next_tx), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .irq_low(irq_low)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic       clr;
        logic       nx;
        logic [2:0] thr;
        logic [7:0] e_tx;
        logic       e_full;
        logic       e_empty;
        logic [2:0] e_cnt;
        logic       e_ovf;
        logic       e_irq;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rs, logic w, logic [7:0] d, logic fl, logic c, logic n,
                                logic [2:0] t, logic [7:0] etx, logic ef, logic ee,
                                logic [2:0] ec, logic eo, logic ei);
        vec_t v;
        v.rstn = rs; v.wr = w; v.d = d; v.fl = fl; v.clr = c; v.nx = n; v.thr = t;
        v.e_tx = etx; v.e_full = ef; v.e_empty = ee; v.e_cnt = ec; v.e_ovf = eo; v.e_irq = ei;
        return v;
    endfunction

    task automatic drive(logic rs, logic w, logic [7:0] d, logic fl, logic c, logic n, logic [2:0] t);
        rstn = rs; wr_en = w; wr_data = d; flush = fl; clr_ovf = c; next_tx = n; thr = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(string name, vec_t v);
        logic [15:0] got;
        logic [15:0] exp;
        got = {tx_data, req, full, empty, count, overflow, irq_low};
        exp = {v.e_tx, ~v.e_empty, v.e_full, v.e_empty, v.e_cnt, v.e_ovf, v.e_irq};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got tx=%h req=%b full=%b empty=%b cnt=%0d ovf=%b irq=%b exp tx=%h req=%b full=%b empty=%b cnt=%0d ovf=%b irq=%b",
                     name, tx_data, req, full, empty, count, overflow, irq_low,
                     v.e_tx, ~v.e_empty, v.e_full, v.e_empty, v.e_cnt, v.e_ovf, v.e_irq);
        end
    endtask

    task automatic check_val(string name, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    initial begin
        logic [7:0] model[$];
        logic [7:0] nd;

        rstn = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        clr_ovf = 1'b0; next_tx = 1'b0; thr = 3'd1;

        //                rs wr data   fl clr nx thr   tx     full empty cnt ovf irq
        vq.push_back(mk(0, 0, 8'h00, 0, 0, 0, 3'd1, 8'hFF, 0, 1, 3'd0, 0, 1));
        vq.push_back(mk(1, 1, 8'h55, 0, 0, 0, 3'd1, 8'h55, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 1, 8'hA3, 0, 0, 0, 3'd1, 8'h55, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'hA3, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'hFF, 0, 1, 3'd0, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'hFF, 0, 1, 3'd0, 0, 1));
        vq.push_back(mk(1, 1, 8'h01, 0, 0, 0, 3'd1, 8'h01, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 1, 8'h02, 0, 0, 0, 3'd1, 8'h01, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 1, 8'h03, 0, 0, 0, 3'd1, 8'h01, 0, 0, 3'd3, 0, 0));
        vq.push_back(mk(1, 1, 8'h04, 0, 0, 0, 3'd1, 8'h01, 1, 0, 3'd4, 0, 0));
        vq.push_back(mk(1, 1, 8'h05, 0, 0, 0, 3'd1, 8'h01, 1, 0, 3'd4, 1, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 3'd1, 8'h01, 1, 0, 3'd4, 0, 0));
        vq.push_back(mk(1, 1, 8'h06, 0, 1, 1, 3'd1, 8'h02, 0, 0, 3'd3, 1, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'h03, 0, 0, 3'd2, 1, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'h04, 0, 0, 3'd1, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'hFF, 0, 1, 3'd0, 1, 1));
        vq.push_back(mk(1, 1, 8'h77, 0, 0, 1, 3'd1, 8'h77, 0, 0, 3'd1, 1, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 1, 0, 3'd1, 8'h77, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 1, 8'h88, 0, 0, 0, 3'd1, 8'h77, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 1, 8'h99, 0, 0, 0, 3'd1, 8'h77, 0, 0, 3'd3, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'h88, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 1, 3'd1, 8'h99, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 3'd0, 8'h99, 0, 0, 3'd1, 0, 0));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 3'd4, 8'h99, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 3'd7, 8'h99, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 1, 8'hAA, 0, 0, 0, 3'd1, 8'h99, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 1, 8'hBB, 0, 0, 0, 3'd1, 8'h99, 0, 0, 3'd3, 0, 0));
        vq.push_back(mk(1, 1, 8'hCC, 1, 0, 1, 3'd1, 8'hFF, 0, 1, 3'd0, 0, 1));
        vq.push_back(mk(1, 1, 8'h11, 0, 0, 0, 3'd1, 8'h11, 0, 0, 3'd1, 0, 1));
        vq.push_back(mk(1, 1, 8'h22, 0, 0, 0, 3'd1, 8'h11, 0, 0, 3'd2, 0, 0));
        vq.push_back(mk(1, 1, 8'h33, 0, 0, 0, 3'd1, 8'h11, 0, 0, 3'd3, 0, 0));
        vq.push_back(mk(1, 1, 8'h44, 0, 0, 0, 3'd1, 8'h11, 1, 0, 3'd4, 0, 0));
        vq.push_back(mk(1, 1, 8'h55, 0, 0, 0, 3'd1, 8'h11, 1, 0, 3'd4, 1, 0));
        vq.push_back(mk(1, 0, 8'h00, 1, 0, 0, 3'd1, 8'hFF, 0, 1, 3'd0, 1, 1));
        vq.push_back(mk(1, 1, 8'h66, 0, 0, 0, 3'd1, 8'h66, 0, 0, 3'd1, 1, 1));
        vq.push_back(mk(1, 1, 8'h67, 0, 0, 0, 3'd1, 8'h66, 0, 0, 3'd2, 1, 0));
        vq.push_back(mk(0, 1, 8'h68, 0, 0, 1, 3'd1, 8'hFF, 0, 1, 3'd0, 0, 1));
        vq.push_back(mk(1, 0, 8'h00, 0, 0, 0, 3'd0, 8'hFF, 0, 1, 3'd0, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rstn, vq[i].wr, vq[i].d, vq[i].fl, vq[i].clr, vq[i].nx, vq[i].thr);
            check_vec($sformatf("vec%0d", i), vq[i]);
        end

        // Wrap: steady occupancy of 2 with simultaneous write and pop each cycle.
        drive(1, 1, 8'hA0, 0, 0, 0, 3'd1);
        model.push_back(8'hA0);
        drive(1, 1, 8'hA1, 0, 0, 0, 3'd1);
        model.push_back(8'hA1);
        check_val("wrap_fill_cnt", {5'd0, count}, 8'd2);
        for (int i = 0; i < 10; i++) begin
            nd = 8'hB0 + 8'(i);
            drive(1, 1, nd, 0, 0, 1, 3'd1);
            void'(model.pop_front());
            model.push_back(nd);
            check_val($sformatf("wrap_head%0d", i), tx_data, model[0]);
            check_val($sformatf("wrap_cnt%0d", i), {5'd0, count}, 8'd2);
        end
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("drain_head%0d", i), tx_data, model[0]);
            drive(1, 0, 8'h00, 0, 0, 1, 3'd1);
            void'(model.pop_front());
        end
        check_val("drain_empty", {7'd0, empty}, 8'd1);
        check_val("drain_tx", tx_data, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
